jtframe_mixseq: RTL and testbench

JTFRAME_MIXSEQ -- requirements
Module: jtframe_mixseq

---
 rtl/jtframe_mixseq.sv | 140 ++++++++++++++
 tb/tb_jtframe_mixseq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mixseq.sv
// Sequential CH-channel gain mixer: one signed x unsigned-4.4 product per clk, then shift and saturate.
// Clip indicator (peak) is compiled in only when JTFRAME_MIXSEQ_PEAK_EN is defined.
module jtframe_mixseq #(
    parameter int CH       = 4,
    parameter int W        = 16,
    parameter int WOUT     = 16,
    parameter int PEAKHOLD = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic [CH*W-1:0]        ch,
    input  logic [CH*8-1:0]        gain,
    output logic signed [WOUT-1:0] mixed,
    output logic                   sample,
    output logic                   busy,
    output logic                   peak
);
    localparam int KW = $clog2(CH);
    localparam int PW = WOUT + 9;
    localparam int AW = PW + KW;
    localparam logic signed [AW-1:0] MAXV = {{(AW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, SAT = 2'd2} state_t;

    state_t                 r_state;
    logic [CH*W-1:0]        r_ch;
    logic [CH*8-1:0]        r_gain;
    logic [KW-1:0]          r_idx;
    logic signed [AW-1:0]   r_acc;

    logic signed [W-1:0]    w_smp;
    logic [7:0]             w_g;
    logic signed [WOUT-1:0] w_scaled;
    logic signed [PW-1:0]   w_sx;
    logic signed [PW-1:0]   w_gx;
    logic signed [PW-1:0]   w_prod;
    logic signed [AW-1:0]   w_shift;
    logic                   w_hi;
    logic                   w_lo;
    logic signed [WOUT-1:0] w_sat;

    // Current channel product: sample aligned to the output width, times the zero-extended gain
    always_comb begin
        w_smp    = r_ch[int'(r_idx)*W +: W];
        w_g      = r_gain[int'(r_idx)*8 +: 8];
        w_scaled = WOUT'(w_smp) <<< (WOUT - W);
        w_sx     = PW'(w_scaled);
        w_gx     = PW'($signed({1'b0, w_g}));
        w_prod   = w_sx * w_gx;
    end

    // Drop the 4 fractional gain bits and clamp to the signed output range
    always_comb begin
        w_shift = r_acc >>> 4;
        w_hi    = (w_shift > MAXV);
        w_lo    = (w_shift < MINV);
        if (w_hi) begin
            w_sat = MAXV[WOUT-1:0];
        end else if (w_lo) begin
            w_sat = MINV[WOUT-1:0];
        end else begin
            w_sat = w_shift[WOUT-1:0];
        end
    end

    // Mix sequencer with registered mixed/sample/busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= {(CH*W){1'b0}};
            r_gain  <= {(CH*8){1'b0}};
            r_idx   <= {KW{1'b0}};
            r_acc   <= {AW{1'b0}};
            mixed   <= {WOUT{1'b0}};
            sample  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            sample <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Also reached on the sample clk, so a cen there starts the next mix
                    if (cen) begin
                        r_ch    <= ch;
                        r_gain  <= gain;
                        r_acc   <= {AW{1'b0}};
                        r_idx   <= {KW{1'b0}};
                        busy    <= 1'b1;
                        r_state <= ACC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    if (r_idx == KW'(CH - 1)) begin
                        r_state <= SAT;
                    end else begin
                        r_idx <= r_idx + KW'(1);
                    end
                end
                SAT: begin
                    mixed   <= w_sat;
                    sample  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef JTFRAME_MIXSEQ_PEAK_EN
    logic [15:0] r_pcnt;
    logic        r_peak;

    // Peak hold: reload on every clip, then count down and drop the flag at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= 16'd0;
            r_peak <= 1'b0;
        end else if ((r_state == SAT) && (w_hi || w_lo)) begin
            r_pcnt <= 16'(PEAKHOLD);
            r_peak <= 1'b1;
        end else if (r_pcnt != 16'd0) begin
            r_pcnt <= r_pcnt - 16'd1;
            r_peak <= (r_pcnt > 16'd1);
        end else begin
            r_peak <= 1'b0;
        end
    end

    assign peak = r_peak;
`else
    assign peak = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_mixseq.sv
// Bench for jtframe_mixseq: cycle-level behavioural model plus directed literal cases and random traffic.
module tb_jtframe_mixseq;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen = 1'b0;
    logic [63:0]        ch = 64'd0;
    logic [31:0]        gain = 32'd0;
    logic signed [15:0] mixed;
    logic               sample, busy, peak;

    logic               b_cen = 1'b0;
    logic [23:0]        b_ch = 24'd0;
    logic [23:0]        b_gain = 24'd0;
    logic signed [15:0] b_mixed;
    logic               b_sample, b_busy, b_peak;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jtframe_mixseq #(.CH(4), .W(16), .WOUT(16), .PEAKHOLD(1024)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .ch(ch), .gain(gain),
        .mixed(mixed), .sample(sample), .busy(busy), .peak(peak)
    );

    jtframe_mixseq #(.CH(3), .W(8), .WOUT(16), .PEAKHOLD(3)) u_dut8 (
        .clk(clk), .rst(rst), .cen(b_cen), .ch(b_ch), .gain(b_gain),
        .mixed(b_mixed), .sample(b_sample), .busy(b_busy), .peak(b_peak)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference mix: exact integer sum of gain-weighted samples, floor-divided by 16, clamped
    function automatic longint mix_ref(input logic [63:0] c, input logic [63:0] g, input int n,
                                       input int w, input int wout, output bit clip);
        longint s, x, gk, lim;
        s = 0;
        for (int k = 0; k < n; k++) begin
            x = longint'((c >> (k * w)) & ((64'd1 << w) - 64'd1));
            if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
            gk = longint'((g >> (k * 8)) & 64'hFF);
            s = s + x * (longint'(1) << (wout - w)) * gk;
        end
        s = s >>> 4;
        lim = longint'(1) << (wout - 1);
        clip = 1'b0;
        if (s > lim - 1) begin
            s = lim - 1;
            clip = 1'b1;
        end else if (s < -lim) begin
            s = -lim;
            clip = 1'b1;
        end
        return s;
    endfunction

    // Model state for the main instance: clk edges left until the sample edge, pending result
    int     m_left = 0;
    longint m_res = 0;
    longint m_mixed = 0;
    bit     m_sample = 1'b0;
    bit     m_resclip = 1'b0;
    int     m_pk = 0;

    // Inputs change 1 time unit after negedge, so at negedge they still hold the last posedge's values
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_left = 0; m_mixed = 0; m_sample = 1'b0; m_pk = 0;
            end else begin
                m_sample = 1'b0;
                if (m_pk > 0) m_pk--;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mixed  = m_res;
                        m_sample = 1'b1;
                        if (m_resclip) m_pk = 1024;
                    end
                end else if (cen) begin
                    m_res  = mix_ref(ch, {32'd0, gain}, 4, 16, 16, m_resclip);
                    m_left = 4 + 1;
                end
            end
            chk("mixed", mixed, m_mixed);
            chk("sample", sample, m_sample);
            chk("busy", busy, (m_left > 0 || m_sample) ? 1 : 0);
`ifdef JTFRAME_MIXSEQ_PEAK_EN
            chk("peak", peak, (m_pk > 0) ? 1 : 0);
`else
            chk("peak", peak, 0);
`endif
        end
    end

    task automatic run_mix(input logic [63:0] c, input logic [31:0] g, input longint exp, input string nm);
        int lat;
        bit seen;
        @(negedge clk); #1;
        ch = c; gain = g; cen = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            cen = 1'b0;
            lat++;
            if (sample) seen = 1'b1;
        end
        chk({nm, "_lat"}, lat, 6);
        chk({nm, "_val"}, mixed, exp);
    endtask

    task automatic run_b(input logic [23:0] c, input logic [23:0] g, input longint exp, input string nm);
        int lat;
        bit seen;
        @(negedge clk); #1;
        b_ch = c; b_gain = g; b_cen = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            b_cen = 1'b0;
            lat++;
            if (b_sample) seen = 1'b1;
        end
        chk({nm, "_lat"}, lat, 5);
        chk({nm, "_val"}, b_mixed, exp);
    endtask

    initial begin
        int     pulses;
        int     pc;
        bit     dummy;
        longint e;
        logic [23:0] rc, rg;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("rst_mixed", mixed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sample", sample, 0);
        chk("rst_peak", peak, 0);

        run_mix({16'h0000, 16'd200, 16'hFE0C, 16'd1000}, 32'h10101010, 700, "basic");
        run_mix({4{16'h7FFF}}, 32'h10101010, 32767, "clip_pos");
`ifdef JTFRAME_MIXSEQ_PEAK_EN
        pc = 0;
        for (int i = 0; i < 1100; i++) begin
            if (peak) pc++;
            @(negedge clk); #1;
        end
        chk("peak_len", pc, 1024);
`endif
        run_mix({4{16'h8000}}, 32'hFFFFFFFF, -32768, "clip_neg");
        run_mix({48'h0, 16'd100}, 32'h000000FF, 1593, "gain_ff_pos");
        run_mix({48'h0, 16'hFF9C}, 32'h000000FF, -1594, "gain_ff_neg");
        run_mix({4{16'h7FFF}}, 32'h00000000, 0, "gain_zero");
        run_mix({16'd0, 16'd0, 16'd3000, 16'h7FFF}, 32'h00002000, 6000, "gain_mix");

        // cen repeated on clk 2 and 3 of a mix is ignored; cen on the sample clk starts a new mix
        @(negedge clk); #1; ch = {48'h0, 16'd1000}; gain = 32'h10; cen = 1'b1;
        @(negedge clk); #1; cen = 1'b0;
        @(negedge clk); #1; cen = 1'b1; ch = {48'h0, 16'd5};
        @(negedge clk); #1; cen = 1'b1;
        @(negedge clk); #1; cen = 1'b0; ch = {48'h0, 16'd2000};
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (sample) begin
                pulses++;
                if (pulses == 1) begin
                    chk("rep_first", mixed, 1000);
                    cen = 1'b1;
                end
            end else begin
                cen = 1'b0;
            end
            @(negedge clk); #1;
        end
        chk("rep_pulses", pulses, 2);
        chk("rep_second", mixed, 2000);

        // reset on clk 3 of a mix aborts it silently
        @(negedge clk); #1; ch = {48'h0, 16'd1234}; gain = 32'h10; cen = 1'b1;
        @(negedge clk); #1; cen = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
        chk("abort_mixed", mixed, 0);
        chk("abort_busy", busy, 0);
        chk("abort_peak", peak, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample) pulses++;
            @(negedge clk); #1;
        end
        chk("abort_pulses", pulses, 0);

        // narrow-input instance: samples are left-aligned to the output width
        run_b({16'h0000, 8'h40}, 24'h000008, 8192, "w8_basic");
        run_b({3{8'h80}}, 24'hFFFFFF, -32768, "w8_clip_neg");
        run_b({8'h00, 8'h00, 8'h7F}, 24'h000010, 32512, "w8_max");
        for (int i = 0; i < 12; i++) begin
            rc = 24'($urandom);
            rg = 24'($urandom);
            e  = mix_ref({40'd0, rc}, {40'd0, rg}, 3, 8, 16, dummy);
            run_b(rc, rg, e, "w8_rand");
        end

        // random traffic on the main instance, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            ch   = {$urandom, $urandom};
            gain = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                gain = gain & 32'h0F0F0F0F;
            end
            cen  = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk); #1;
        cen = 1'b0; rst = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
